backoff_retry_ctrl: RTL



---
 rtl/backoff_retry_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/backoff_retry_ctrl.sv
// Retry controller in front of an exponential backoff counter: issues a request as
// trials, pulses set on nack / clr on completion or flush, and reports outcome and retry count.
module backoff_retry_ctrl #(
    parameter int MaxRetries = 8,
    parameter int DataWidth  = 32,
    localparam int RetryW    = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 trial_valid_o,
    input  logic                 trial_ready_i,
    output logic [DataWidth-1:0] trial_data_o,
    input  logic                 resp_valid_i,
    input  logic                 resp_ok_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic                 done_ok_o,
    output logic [RetryW-1:0]    done_retries_o,
    output logic                 backoff_set_o,
    output logic                 backoff_clr_o,
    input  logic                 backoff_zero_i
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_ISSUE, ST_RESP, ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [RetryW-1:0]      retry_q, retry_d;
    logic                   ok_q, ok_d;
    logic                   resp_fire;
    logic                   at_limit;
    logic                   flush_act;

    assign resp_fire = (state_q == ST_RESP) && resp_valid_i;
    assign at_limit  = (retry_q == RetryW'(MaxRetries));
    // Flush is meaningless in IDLE; a request arriving alongside it is still taken.
    assign flush_act = flush_i && (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            retry_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        retry_d = retry_q;
        ok_d    = ok_q;
        unique case (state_q)
            ST_IDLE: if (req_valid_i) begin
                state_d = ST_WAIT;
                data_d  = req_data_i;
                retry_d = '0;
                ok_d    = 1'b0;
            end
            ST_WAIT:  if (backoff_zero_i) state_d = ST_ISSUE;
            ST_ISSUE: if (trial_ready_i)  state_d = ST_RESP;
            ST_RESP: if (resp_valid_i) begin
                if (resp_ok_i) begin
                    state_d = ST_DONE;
                    ok_d    = 1'b1;
                end else if (!at_limit) begin
                    state_d = ST_WAIT;
                    retry_d = retry_q + RetryW'(1);
                end else begin
                    state_d = ST_DONE;
                    ok_d    = 1'b0;
                end
            end
            ST_DONE:  if (done_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush_act) begin
            state_d = ST_IDLE;
            retry_d = retry_q;
            ok_d    = ok_q;
        end
    end

    always_comb begin
        req_ready_o    = (state_q == ST_IDLE);
        trial_valid_o  = (state_q == ST_ISSUE);
        done_valid_o   = (state_q == ST_DONE);
        trial_data_o   = data_q;
        done_ok_o      = ok_q;
        done_retries_o = retry_q;
        // Pulses coincide with the consuming edge so the counter reloads before WAIT looks at it.
        backoff_set_o  = resp_fire && !flush_act && !resp_ok_i && !at_limit;
        backoff_clr_o  = flush_act || (resp_fire && (resp_ok_i || at_limit));
    end

endmodule
